// File: rtl/muldiv_ctrl_if.sv
// EX-stage request and HILO result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives the request side (master); muldiv_ctrl consumes it (slave).
interface muldiv_ctrl_if;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, flush, input stall, hilo_we, hi, lo);
  modport slave  (input start, op, a, b, flush, output stall, hilo_we, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: 1-cycle multiply, 32-cycle restoring divide, HILO strobe in DONE.
// Latency start->hilo_we: 2 (mul), 33 (div), 1 (divide by zero); stall holds the pipeline meanwhile.
module muldiv_ctrl (
  input  logic         clk,
  input  logic         resetn,
  muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        sgn_q, sgn_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        launch;
  logic        sdiv;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod;
  logic [32:0] div_shift, div_diff;
  logic [31:0] div_quo, div_rem;

  assign launch = bus.start && !bus.flush;
  assign sdiv   = (bus.op == 2'b10);
  assign a_mag  = (sdiv && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag  = (sdiv && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  // Sign-extending into 64 bits makes one unsigned multiplier serve both MULT and MULTU.
  assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

  // a_q doubles as the quotient shift register; its MSB feeds the partial remainder.
  assign div_shift = {rem_q, a_q[31]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_quo   = {a_q[30:0], ~div_diff[32]};
  assign div_rem   = div_diff[32] ? div_shift[31:0] : div_diff[31:0];

  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          sgn_d = !bus.op[0];
          if (!bus.op[1]) begin
            a_d     = bus.a;
            b_d     = bus.b;
            state_d = S_MUL;
          end else if (bus.b == 32'd0) begin
            hi_d    = bus.a;
            lo_d    = 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else begin
            a_d     = a_mag;
            b_d     = b_mag;
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            qneg_d  = sdiv && (bus.a[31] ^ bus.b[31]);
            rneg_d  = sdiv && bus.a[31];
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          a_d   = div_quo;
          rem_d = div_rem;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            hi_d    = rneg_q ? (~div_rem + 32'd1) : div_rem;
            lo_d    = qneg_q ? (~div_quo + 32'd1) : div_quo;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Gated by resetn so a request held during reset never stalls the pipeline.
  assign bus.stall   = resetn && (((state_q == S_IDLE) && launch) ||
                                  (state_q == S_MUL) || (state_q == S_DIV));
  assign bus.hilo_we = (state_q == S_DONE) && !bus.flush;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HILO writes are queued at launch and checked by a monitor.
module tb_muldiv_ctrl;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [31:0] prev_hi, prev_lo;

  muldiv_ctrl_if bus();

  muldiv_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every HILO write must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (bus.hilo_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_hilo_we", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", {32'd0, bus.hi}, {32'd0, e.hi});
        chk("lo", {32'd0, bus.lo}, {32'd0, e.lo});
        chk("we_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic push_exp(input logic [31:0] ehi, input logic [31:0] elo, input int at);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv;
    push_exp(ehi, elo, cyc + lat);
    @(negedge clk);
    chk("stall_launch", {63'd0, bus.stall}, 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = ~o; bus.a = $urandom; bus.b = $urandom;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) chk("stall_busy", {63'd0, bus.stall}, 64'd1);
      else         chk("stall_done", {63'd0, bus.stall}, 64'd0);
    end
    @(posedge clk); #1;
    chk("strobe_seen", 64'(sb.size()), 64'd0);
    prev_hi = ehi; prev_lo = elo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b0; bus.op = 2'b00; bus.a = 32'd0; bus.b = 32'd0;
    #3;
    chk("rst_hi", {32'd0, bus.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus.lo}, 64'd0);
    chk("rst_we", {63'd0, bus.hilo_we}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk); @(negedge clk);
    bus.start = 1'b0;
    resetn = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    do_op(2'b01, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 2);
    do_op(2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB,  32'h0000_0000, 32'h0000_000F, 2);
    do_op(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 2);
    do_op(2'b11, 32'd100,       32'd7,          32'd2,         32'd14,        33);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 33);
    do_op(2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 33);
    do_op(2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD,  32'hFFFF_FFFE, 32'd2,         33);
    do_op(2'b11, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF, 33);
    do_op(2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF, 1);
    do_op(2'b10, 32'hFFFF_EDCC, 32'd0,          32'hFFFF_EDCC, 32'hFFFF_FFFF, 1);

    // Flush a DIVU at cycle 10: back to IDLE at 11, never strobes, HILO untouched.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush_div_stall", {63'd0, bus.stall}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_keep_hi", {32'd0, bus.hi}, {32'd0, prev_hi});
    chk("flush_keep_lo", {32'd0, bus.lo}, {32'd0, prev_lo});

    // start together with flush must not launch.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9;
    @(negedge clk);
    chk("start_flush_stall", {63'd0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("start_flush_idle", {63'd0, bus.stall}, 64'd0);
    repeat (4) @(posedge clk);

    // Flush while in DONE suppresses the write strobe.
    #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_done_we", {63'd0, bus.hilo_we}, 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);

    // Back-to-back: MULT then DIVU with start held high throughout.
    #1;
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd6; bus.b = 32'hFFFF_FFF9;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFD6, cyc + 2);
    push_exp(32'd1, 32'd333, cyc + 36);
    @(posedge clk); #1;
    bus.op = 2'b11; bus.a = 32'd1000; bus.b = 32'd3;
    @(negedge clk);
    chk("b2b_stall_mul", {63'd0, bus.stall}, 64'd1);
    @(negedge clk);
    chk("b2b_stall_done", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    chk("b2b_stall_relaunch", {63'd0, bus.stall}, 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("b2b_strobes_seen", 64'(sb.size()), 64'd0);

    // Reset in the middle of a DIVU, then a fresh MULTU.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    resetn = 1'b0; bus.start = 1'b1;
    #1;
    chk("midrst_hi", {32'd0, bus.hi}, 64'd0);
    chk("midrst_lo", {32'd0, bus.lo}, 64'd0);
    chk("midrst_we", {63'd0, bus.hilo_we}, 64'd0);
    chk("midrst_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk); @(negedge clk);
    bus.start = 1'b0;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    do_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 2);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
